// File: rtl/io_port_pkg.sv
// io_port_pkg: register map, reset values and synchroniser depth
// shared by the memory-mapped pin I/O unit and its sub-modules.
package io_port_pkg;

    localparam logic [2:0] ADDR_OUT       = 3'd0;
    localparam logic [2:0] ADDR_UIO_OUT   = 3'd1;
    localparam logic [2:0] ADDR_UIO_OE    = 3'd2;
    localparam logic [2:0] ADDR_IN        = 3'd3;
    localparam logic [2:0] ADDR_UIO_IN    = 3'd4;
    localparam logic [2:0] ADDR_EDGE_ST   = 3'd5;
    localparam logic [2:0] ADDR_EDGE_MASK = 3'd6;
    localparam logic [2:0] ADDR_EDGE_POL  = 3'd7;

    localparam int RST_OUT       = 0;
    localparam int RST_UIO_OUT   = 0;
    localparam int RST_UIO_OE    = 0;
    localparam int RST_EDGE_ST   = 0;
    localparam int RST_EDGE_MASK = 0;
    localparam int RST_EDGE_POL  = 0;

    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/io_sync_edge.sv
// io_sync_edge: per-bit input synchroniser, history flop and edge pulse.
// Ports: clk, rst_n, din (async pins), pol (0 rise / 1 fall), sync, edge_pulse.
module io_sync_edge
    import io_port_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    input  logic [W-1:0] pol,
    output logic [W-1:0] sync,
    output logic [W-1:0] edge_pulse
);

    logic [SYNC_STAGES-1:0][W-1:0] sync_q;
    logic [W-1:0]                  hist_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    // A bit changed, and its new value is the one the polarity asks for:
    // new=1 for rising (pol=0), new=0 for falling (pol=1).
    assign edge_pulse = (sync ^ hist_q) & (sync ^ pol);

endmodule

// File: rtl/io_port_unit.sv
// io_port_unit: bus-programmable pin port with bidirectional pins,
// synchronised inputs, sticky edge flags and a maskable level interrupt.
module io_port_unit
    import io_port_pkg::*;
#(
    parameter int PIN_W  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [PIN_W-1:0]  bus_wdata,
    input  logic              bus_we,
    input  logic              bus_re,
    output logic [PIN_W-1:0]  bus_rdata,
    output logic              bus_ready,
    input  logic [PIN_W-1:0]  pin_in,
    input  logic [PIN_W-1:0]  pin_uio_in,
    output logic [PIN_W-1:0]  pin_out,
    output logic [PIN_W-1:0]  pin_uio_out,
    output logic [PIN_W-1:0]  pin_uio_oe,
    output logic              irq
);

    logic [PIN_W-1:0] out_q;
    logic [PIN_W-1:0] uio_out_q;
    logic [PIN_W-1:0] uio_oe_q;
    logic [PIN_W-1:0] edge_st_q;
    logic [PIN_W-1:0] edge_mask_q;
    logic [PIN_W-1:0] edge_pol_q;

    logic [PIN_W-1:0] in_sync;
    logic [PIN_W-1:0] in_edge;
    logic [PIN_W-1:0] uio_sync;

    logic             addr_ok;
    logic [2:0]       reg_sel;
    logic             wr_en;
    logic             rd_en;
    logic             access;
    logic [PIN_W-1:0] st_clr;
    logic [PIN_W-1:0] rd_mux;

    io_sync_edge #(.W(PIN_W)) u_in_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (pin_in),
        .pol        (edge_pol_q),
        .sync       (in_sync),
        .edge_pulse (in_edge)
    );

    io_sync_edge #(.W(PIN_W)) u_uio_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (pin_uio_in),
        .pol        ('0),
        .sync       (uio_sync),
        .edge_pulse ()
    );

    // Upper address bits must be zero for an access to hit the map.
    assign addr_ok = (bus_addr >> 3) == '0;
    assign reg_sel = bus_addr[2:0];
    assign access  = bus_we | bus_re;
    assign wr_en   = bus_we & addr_ok;
    // A write in the same cycle wins; the read half is dropped.
    assign rd_en   = bus_re & ~bus_we & addr_ok;

    assign st_clr = (wr_en && reg_sel == ADDR_EDGE_ST) ? bus_wdata : '0;

    always_comb begin
        rd_mux = '0;
        unique case (1'b1)
            (reg_sel == ADDR_OUT):       rd_mux = out_q;
            (reg_sel == ADDR_UIO_OUT):   rd_mux = uio_out_q;
            (reg_sel == ADDR_UIO_OE):    rd_mux = uio_oe_q;
            (reg_sel == ADDR_IN):        rd_mux = in_sync;
            (reg_sel == ADDR_UIO_IN):    rd_mux = uio_sync;
            (reg_sel == ADDR_EDGE_ST):   rd_mux = edge_st_q;
            (reg_sel == ADDR_EDGE_MASK): rd_mux = edge_mask_q;
            (reg_sel == ADDR_EDGE_POL):  rd_mux = edge_pol_q;
            default:                     rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= PIN_W'(RST_OUT);
            uio_out_q   <= PIN_W'(RST_UIO_OUT);
            uio_oe_q    <= PIN_W'(RST_UIO_OE);
            edge_mask_q <= PIN_W'(RST_EDGE_MASK);
            edge_pol_q  <= PIN_W'(RST_EDGE_POL);
        end else if (wr_en) begin
            unique case (1'b1)
                (reg_sel == ADDR_OUT):       out_q       <= bus_wdata;
                (reg_sel == ADDR_UIO_OUT):   uio_out_q   <= bus_wdata;
                (reg_sel == ADDR_UIO_OE):    uio_oe_q    <= bus_wdata;
                (reg_sel == ADDR_EDGE_MASK): edge_mask_q <= bus_wdata;
                (reg_sel == ADDR_EDGE_POL):  edge_pol_q  <= bus_wdata;
                default: ;
            endcase
        end
    end

    // A new edge on the same bit as a W1C clear keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_st_q <= PIN_W'(RST_EDGE_ST);
            irq       <= 1'b0;
        end else begin
            edge_st_q <= (edge_st_q & ~st_clr) | in_edge;
            irq       <= |(edge_st_q & edge_mask_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_ready <= 1'b0;
            bus_rdata <= '0;
        end else begin
            bus_ready <= access;
            bus_rdata <= rd_en ? rd_mux : '0;
        end
    end

    assign pin_out     = out_q;
    assign pin_uio_out = uio_out_q;
    assign pin_uio_oe  = uio_oe_q;

endmodule
